rvvi_depacketizer: RTL
======================

// Module: rvvi_depacketizer
// PURPOSE
//  Receive-side counterpart of the RVVI packetizer: consumes the AXI-stream RX output of eth_mac_mii_fifo
//  and rebuilds the RVVI trace record (valid + rvvi vector) for a host-side checker or loopback bench.
//  Validates header and length; delivers good records on a valid/ready port; counts good and bad frames.
// PARAMETERS
//  P          cvw_t config   source of P.XLEN
//  MAX_CSRS   5              CSR slots per record; RVVI_W = 72+5*XLEN+MAX_CSRS*(XLEN+16)
//  ETH_TYPE   16'h005C       required EtherType, header bytes 12..13, big-endian
//  DST_MAC    48'h8F54_0000_1654  expected destination MAC (used only with filter macro)
// PORTS
//  s_axi_aclk     in   1       single clock
//  s_axi_aresetn  in   1       asynchronous active-low reset
//  s_axis_tdata   in   32      RX beat; byte k = tdata[8k+7:8k], byte 0 first on wire
//  s_axis_tkeep   in   4       byte valids; only the final beat may be partial, contiguous from bit 0
//  s_axis_tvalid  in   1       beat valid
//  s_axis_tlast   in   1       last beat of frame
//  s_axis_tuser   in   1       MAC bad-frame/FCS flag, qualified with tlast
//  s_axis_tready  out  1       beat accept
//  rvvi           out  RVVI_W  reconstructed record, record bit 0 = payload byte 0 bit 0
//  rvvi_valid     out  1       record held
//  rvvi_ready     in   1       consumer accept
//  FramesGood     out  16      saturating count of delivered records
//  FramesBad      out  16      saturating count of dropped frames
// BEHAVIOUR
//  Frame: HDR_WORDS=4 header beats (dst MAC 6B, src MAC 6B, EtherType 2B, tag 2B ignored), then
//   PAY_WORDS=ceil(RVVI_W/32) payload beats; tlast on beat 4+PAY_WORDS-1 exactly.
//  Beat transfers when s_axis_tvalid & s_axis_tready.
//  States: IDLE -> HDR (first beat) -> PAY (after beat 3) -> HOLD (after final good beat).
//   Any violation -> DROP; DROP discards through tlast -> IDLE.
//   Violations: EtherType mismatch; tlast before the expected final beat; no tlast on the final beat;
//   tuser=1 with tlast; tkeep != 4'hF on a non-final beat.
//  Beat counter is 8 bits; it does not wrap inside a frame because an over-long frame enters DROP.
//  The payload shift register fills LSB-first at 32 bits/beat; bits above RVVI_W on the final beat are discarded.
//  HOLD: rvvi_valid=1 and rvvi stable until rvvi_ready; on handshake -> IDLE, FramesGood++. Latency from the
//   final beat to rvvi_valid is 1 cycle.
//  s_axis_tready = 1 in IDLE/HDR/PAY/DROP and 0 in HOLD; upstream backpressure stalls the MAC FIFO.
//  A frame ending in DROP increments FramesBad in the cycle its tlast is accepted. A header error and a
//   simultaneous tlast count once. Counters saturate at 16'hFFFF.
//  Reset (async, any state, mid-frame included): state=IDLE, rvvi=0, rvvi_valid=0, counters=0;
//   s_axis_tready=0 while reset is asserted and 1 from the first clock after release. A partially received frame
//   is lost; its remaining beats are taken as a new frame, fail the checks and are counted bad.
// CONFIGURATION
//  RVVI_DEPACKETIZER_MAC_FILTER_EN defined: a destination MAC != DST_MAC is a header violation -> DROP, FramesBad++.
//  Macro undefined: the destination MAC is ignored; the frame is judged on EtherType, length and error checks only.
// TESTING (XLEN=64, MAX_CSRS=5: RVVI_W=792, PAY_WORDS=25, frame=29 beats, final tkeep=4'h7)
//  Good frame, rvvi_ready=1 -> rvvi_valid high 1 cycle after beat 28, rvvi matches sent pattern,
//   FramesGood=1 and FramesBad=0.
//  EtherType 16'h0800 -> no rvvi_valid, all 29 beats accepted, FramesBad=1.
//  tlast on beat 10 -> dropped, FramesBad=1; next good frame is delivered normally.
//  31-beat frame (no tlast at beat 28) -> DROP until tlast, FramesBad=1, no rvvi_valid.
//  rvvi_ready=0 for 20 cycles after a good frame -> tready=0 and rvvi stable for the whole stall;
//   a second queued frame is delivered intact after the handshake and FramesGood=2.
//  Reset pulse at beat 15 -> outputs 0; the 13 trailing beats give FramesBad=1; a following good frame is delivered.
//   With the macro defined, destination MAC 48'hFFFF_FFFF_FFFF -> FramesBad=1.

Source files
------------

// File: rtl/rvvi_depacketizer.sv
`default_nettype none
// ============================================================================
// Module      : rvvi_depacketizer
// Description : Receive-side RVVI trace de-packetizer. Consumes the 32-bit
//               AXI-stream RX output of an Ethernet MAC FIFO, validates the
//               frame header and length, and rebuilds the RVVI trace record.
//               Good records are presented on a valid/ready port. Good and
//               bad frames are counted in saturating 16-bit counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN      architectural register width (sets the record width)
//   MAX_CSRS  CSR slots per record; RVVI_W = 72 + 5*XLEN + MAX_CSRS*(XLEN+16)
//   ETH_TYPE  required EtherType (header bytes 12..13, big-endian)
//   DST_MAC   expected destination MAC (checked only with the filter macro)
// Ports
//   s_axi_aclk     in   1       clock
//   s_axi_aresetn  in   1       asynchronous active-low reset
//   s_axis_tdata   in   32      RX beat, byte k = tdata[8k+7:8k], byte 0 first
//   s_axis_tkeep   in   4       byte valids (only the final beat may be partial)
//   s_axis_tvalid  in   1       beat valid
//   s_axis_tlast   in   1       last beat of frame
//   s_axis_tuser   in   1       MAC bad-frame flag, qualified with tlast
//   s_axis_tready  out  1       beat accept (low while a record is held)
//   rvvi           out  RVVI_W  reconstructed record, bit 0 = payload byte 0 bit 0
//   rvvi_valid     out  1       record held
//   rvvi_ready     in   1       consumer accept
//   FramesGood     out  16      saturating count of delivered records
//   FramesBad      out  16      saturating count of dropped frames
// Configuration macro
//   RVVI_DEPACKETIZER_MAC_FILTER_EN : when defined, a destination MAC that
//   differs from DST_MAC is a header violation and the frame is dropped.
// ============================================================================
module rvvi_depacketizer #(
  parameter int          XLEN     = 64,
  parameter int          MAX_CSRS = 5,
  parameter logic [15:0] ETH_TYPE = 16'h005C,
  parameter logic [47:0] DST_MAC  = 48'h8F54_0000_1654,
  localparam int         RVVI_W   = 72 + 5*XLEN + MAX_CSRS*(XLEN+16)
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [31:0]       s_axis_tdata,
  input  logic [3:0]        s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              s_axis_tready,
  output logic [RVVI_W-1:0] rvvi,
  output logic              rvvi_valid,
  input  logic              rvvi_ready,
  output logic [15:0]       FramesGood,
  output logic [15:0]       FramesBad
);

  localparam int         HDR_WORDS      = 4;
  localparam int         PAY_WORDS      = (RVVI_W + 31) / 32;
  localparam int         LAST_WORD_BITS = RVVI_W - 32*(PAY_WORDS-1);
  localparam logic [7:0] LAST_BEAT      = 8'(HDR_WORDS + PAY_WORDS - 1);
  localparam logic [7:0] ETYPE_BEAT     = 8'(HDR_WORDS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_en_q, ready_en_d;
  logic [15:0] frames_good_q, frames_good_d;
  logic [15:0] frames_bad_q, frames_bad_d;

  logic        w_in_frame;
  logic        w_accept;
  logic [7:0]  w_beat_idx;
  logic [7:0]  w_word_idx;
  logic        w_is_last;
  logic [15:0] w_eth_type;
  logic        w_mac_err;
  logic        w_hdr_err;
  logic        w_viol;
  logic        w_bad_end;
  logic        w_pay_we;
  logic        w_deliver;
  wire  [RVVI_W-1:0] w_rvvi;

  // --------------------------------------------------------------------------
  // Beat classification
  // --------------------------------------------------------------------------
  assign w_in_frame = (state_q == S_IDLE) || (state_q == S_HDR) || (state_q == S_PAY);
  assign w_accept   = s_axis_tvalid & s_axis_tready;
  // The first beat of a frame is the one accepted in IDLE; the counter holds
  // the index of the next expected beat afterwards.
  assign w_beat_idx = (state_q == S_IDLE) ? 8'd0 : cnt_q;
  assign w_word_idx = w_beat_idx - 8'(HDR_WORDS);
  assign w_is_last  = (w_beat_idx == LAST_BEAT);
  assign w_eth_type = {s_axis_tdata[7:0], s_axis_tdata[15:8]};

`ifdef RVVI_DEPACKETIZER_MAC_FILTER_EN
  // Destination MAC spans beat 0 (bytes 0..3) and the low half of beat 1.
  assign w_mac_err =
      ((w_beat_idx == 8'd0) &&
       (s_axis_tdata != {DST_MAC[23:16], DST_MAC[31:24], DST_MAC[39:32], DST_MAC[47:40]})) ||
      ((w_beat_idx == 8'd1) &&
       (s_axis_tdata[15:0] != {DST_MAC[7:0], DST_MAC[15:8]}));
`else
  assign w_mac_err = 1'b0;
`endif

  assign w_hdr_err = ((w_beat_idx == ETYPE_BEAT) && (w_eth_type != ETH_TYPE)) || w_mac_err;

  // tlast must appear on exactly the final beat, so any disagreement between
  // tlast and the final-beat position is a length error (early or late).
  assign w_viol = w_hdr_err
                | (s_axis_tlast ^ w_is_last)
                | (s_axis_tlast & s_axis_tuser)
                | (~w_is_last & (s_axis_tkeep != 4'hF));

  // A violation on the tlast beat itself ends the frame right here, so it is
  // counted once without passing through DROP.
  assign w_bad_end = w_accept & s_axis_tlast &
                     ((w_in_frame & w_viol) | (state_q == S_DROP));
  assign w_pay_we  = w_accept & (state_q == S_PAY);
  assign w_deliver = (state_q == S_HOLD) & rvvi_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HDR, S_PAY: begin
        if (w_accept) begin
          if (w_viol) begin
            state_d = s_axis_tlast ? S_IDLE : S_DROP;
          end else if (w_is_last) begin
            state_d = S_HOLD;
          end else if (w_beat_idx == ETYPE_BEAT) begin
            state_d = S_PAY;
          end else if (state_q == S_IDLE) begin
            state_d = S_HDR;
          end
        end
      end
      S_HOLD: begin
        if (rvvi_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_accept && s_axis_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // ready_en_q keeps tready low during reset and releases it on the first
  // clock after reset deasserts.
  always_comb begin
    s_axis_tready = ready_en_q & (state_q != S_HOLD);
    rvvi_valid    = (state_q == S_HOLD);
  end

  // --------------------------------------------------------------------------
  // Beat counter and frame counters
  // --------------------------------------------------------------------------
  always_comb begin
    ready_en_d    = 1'b1;
    cnt_d         = cnt_q;
    frames_good_d = frames_good_q;
    frames_bad_d  = frames_bad_q;
    if (w_accept && w_in_frame) begin
      cnt_d = w_beat_idx + 8'd1;
    end
    if (w_deliver && (frames_good_q != 16'hFFFF)) begin
      frames_good_d = frames_good_q + 16'd1;
    end
    if (w_bad_end && (frames_bad_q != 16'hFFFF)) begin
      frames_bad_d = frames_bad_q + 16'd1;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ready_en_q    <= 1'b0;
      cnt_q         <= 8'd0;
      frames_good_q <= 16'd0;
      frames_bad_q  <= 16'd0;
    end else begin
      ready_en_q    <= ready_en_d;
      cnt_q         <= cnt_d;
      frames_good_q <= frames_good_d;
      frames_bad_q  <= frames_bad_d;
    end
  end

  // --------------------------------------------------------------------------
  // Record storage: one register per payload word, written in place by word
  // index. The final word keeps only the bits that belong to the record.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < PAY_WORDS; k++) begin : g_word
    localparam int WORD_BITS = (k == PAY_WORDS-1) ? LAST_WORD_BITS : 32;

    logic [WORD_BITS-1:0] word_q, word_d;
    logic                 w_we;

    assign w_we = w_pay_we && (w_word_idx == 8'(k));

    always_comb begin
      word_d = word_q;
      if (w_we) begin
        word_d = s_axis_tdata[WORD_BITS-1:0];
      end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign w_rvvi[32*k +: WORD_BITS] = word_q;
  end

  assign rvvi       = w_rvvi;
  assign FramesGood = frames_good_q;
  assign FramesBad  = frames_bad_q;

endmodule
`default_nettype wire
